guess_checker: RTL and testbench
================================

Name: guess_checker

Overview:
- Game-play stage directly downstream of the host message register.
- Latches the 40-bit secret word (5 ASCII bytes, 0x5F = unused position) when the host stage asserts rec_ready.
- Then processes player letter guesses one at a time. Maintains revealed-word display, used-letter bitmap and mistake count; declares win/lose.
- Produces the game_end pulse that feeds the host stage's gameEnd_host input.

Parameters:
- MAX_MISTAKES, 6, misses that cause LOSE; legal range 1..15.

Ports:
- clk  in  1  clock
- nRst  in  1  asynchronous, active-low reset
- rec_ready  in  1  host word complete (from host stage)
- secret_word  in  40  host word; position 0 = [39:32] ... position 4 = [7:0]
- guess_valid  in  1  one-cycle strobe, guess_letter valid
- guess_letter  in  8  ASCII guess
- restart  in  1  player request to end/abort game
- display_word  out  40  revealed word, unrevealed bytes = 0x5F
- used_letters  out  26  bit n set = letter 'A'+n already guessed
- mistakes  out  4  miss count
- hit  out  1  one-cycle pulse, new guess matched
- miss  out  1  one-cycle pulse, new guess did not match
- dup  out  1  one-cycle pulse, guess already used
- busy  out  1  high in CHECK; guesses ignored
- win  out  1  level, high in WIN
- lose  out  1  level, high in LOSE
- game_end  out  1  one-cycle pulse, to host gameEnd_host

Behaviour:
- Reset values: state IDLE, display_word 40'h5F5F5F5F5F, used_letters 0, mistakes 0. All pulses, win, lose and busy are 0. Internal secret 0, reveal mask 0, rec_ready_q 0.
- Internal registers:
  - secret: 40-bit copy of the word.
  - mask: 5 bits, bit i = position i revealed.
  - guess_q: 5-bit letter index.
  - rec_ready_q: previous-cycle rec_ready.
- display byte i = mask[i] ? secret byte i : 0x5F.
- Letter decode:
  - 0x41..0x5A gives index = byte-0x41.
  - 0x61..0x7A is folded to uppercase, index = byte-0x61.
  - Anything else is invalid.
- IDLE:
  - On rec_ready=1 with rec_ready_q=0 (rising edge): latch secret_word.
  - mask[i]=1 for every position whose byte is not A..Z; clear used/mistakes; go PLAY.
  - A level-high rec_ready without a rising edge does not load.
- PLAY:
  - If mask==5'b11111 (no letters in word): go WIN next cycle, guesses ignored.
  - Otherwise, guess_valid with valid letter: capture index into guess_q, go CHECK.
  - Invalid letter, or no strobe: stay PLAY, no pulse.
- CHECK (exactly one cycle, busy=1, guess_valid ignored):
  - used bit set: dup=1, no other change, go PLAY.
  - Else set used bit. match[i] = secret byte i == 'A'+guess_q.
  - Any match: mask |= match, hit=1; go WIN if the new mask is all ones, else PLAY.
  - No match: mistakes+1, miss=1; go LOSE if the new count == MAX_MISTAKES, else PLAY.
- Latency:
  - Guess strobe at edge N is registered at N.
  - display/used/mistakes/pulses update at edge N+1.
  - Next guess accepted from edge N+2.
- Pulses (hit/miss/dup/game_end) are registered, high for exactly one cycle after the updating edge.
- WIN: win=1, display frozen. LOSE: lose=1, mask forced to all ones so display shows the full secret.
- restart in PLAY, CHECK, WIN or LOSE:
  - next edge → IDLE; clear display/used/mistakes/mask.
  - game_end=1 for one cycle. A CHECK in progress is discarded (no hit/miss/dup).
- restart in IDLE: ignored, no game_end.
- restart and guess_valid in the same cycle: restart wins.
- rec_ready low in any non-IDLE state (host reset): → IDLE, clear everything, no game_end pulse.
- mistakes saturates at MAX_MISTAKES; never wraps.
- Async nRst at any time returns all registers to reset values immediately.

Test Plan:
- Load "APPLE" (41 50 50 4C 45, rising rec_ready), guess 'P' → after 2 edges display 5F50505F5F, hit pulse 1 cycle, used_letters bit 15 set, mistakes 0.
- Continue: guess 'a','l','e' → WIN, win=1, display 4150504C45. Then restart → game_end one cycle, state IDLE, display 5F5F5F5F5F.
- Load "APPLE", guess 'Z','Q','X','M','N','B' → miss each; mistakes 1..6, then LOSE, lose=1, display shows 4150504C45.
- Guess 'P' twice → second gives dup pulse, mistakes and used unchanged. Guess '3' and guess during busy → no pulse, no state change.
- Secret 41 5F 5F 5F 5F ("A____") → guess 'A' → WIN. Secret all 5F → WIN with no guess.
- Mid-game rec_ready drop → IDLE, no game_end. rec_ready held high afterward → no reload until next rising edge. nRst mid-CHECK → all outputs at reset values.

Source files
------------

// File: rtl/guess_checker.sv
// guess_checker: game-play stage of the letter-guessing game.
//
// Latches a 5-byte secret word from the host stage on a rising rec_ready.
// Then scores player letter guesses one at a time. It maintains the revealed
// display, the used-letter bitmap and the mistake count, and declares win or
// lose. It also emits the game_end pulse that goes back to the host stage.
//
// Ports:
//   clk, nRst     clock, asynchronous active-low reset
//   rec_ready     host word complete; dropping it while in a game aborts silently
//   secret_word   host word, position 0 = [39:32] ... position 4 = [7:0]
//   guess_valid   one-cycle strobe qualifying guess_letter
//   guess_letter  ASCII guess; lowercase is folded to uppercase
//   restart       player abort/end request
//   display_word  revealed word, hidden bytes read 0x5F
//   used_letters  bit n set = letter 'A'+n already guessed
//   mistakes      miss count, saturates at MAX_MISTAKES
//   hit/miss/dup  one-cycle result pulses for a scored guess
//   busy          high while a guess is being scored (guesses ignored)
//   win/lose      game outcome levels
//   game_end      one-cycle pulse on a player restart
module guess_checker #(
    parameter int unsigned MAX_MISTAKES = 6
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        rec_ready,
    input  logic [39:0] secret_word,
    input  logic        guess_valid,
    input  logic [7:0]  guess_letter,
    input  logic        restart,
    output logic [39:0] display_word,
    output logic [25:0] used_letters,
    output logic [3:0]  mistakes,
    output logic        hit,
    output logic        miss,
    output logic        dup,
    output logic        busy,
    output logic        win,
    output logic        lose,
    output logic        game_end
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLAY,
        S_CHECK,
        S_WIN,
        S_LOSE
    } state_t;

    localparam logic [3:0] MAX_M = 4'(MAX_MISTAKES);

    state_t         state;
    logic [39:0]    secret;
    logic [4:0]     mask;
    logic [4:0]     guess_q;
    logic           rec_ready_q;

    logic [4:0][7:0] sec_b;
    logic [4:0][7:0] in_b;
    logic [4:0][7:0] disp_b;
    logic [4:0]      load_mask;
    logic [4:0]      match;
    logic            guess_ok;
    logic [4:0]      guess_idx;

    // Packed byte views: position i lives in element 4-i.
    assign sec_b = secret;
    assign in_b  = secret_word;

    always_comb begin
        guess_ok  = 1'b0;
        guess_idx = '0;
        if (guess_letter >= 8'h41 && guess_letter <= 8'h5A) begin
            guess_ok  = 1'b1;
            guess_idx = 5'(guess_letter - 8'h41);
        end else if (guess_letter >= 8'h61 && guess_letter <= 8'h7A) begin
            guess_ok  = 1'b1;
            guess_idx = 5'(guess_letter - 8'h61);
        end
    end

    always_comb begin
        load_mask = '0;
        match     = '0;
        disp_b    = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            // Positions that are not A..Z are shown from the start.
            load_mask[i] = !(in_b[4-i] >= 8'h41 && in_b[4-i] <= 8'h5A);
            match[i]     = (sec_b[4-i] == (8'h41 + {3'b000, guess_q}));
            disp_b[4-i]  = mask[i] ? sec_b[4-i] : 8'h5F;
        end
    end

    assign display_word = disp_b;
    assign busy         = (state == S_CHECK);
    assign win          = (state == S_WIN);
    assign lose         = (state == S_LOSE);

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state        <= S_IDLE;
            secret       <= '0;
            mask         <= '0;
            guess_q      <= '0;
            rec_ready_q  <= 1'b0;
            used_letters <= '0;
            mistakes     <= '0;
            hit          <= 1'b0;
            miss         <= 1'b0;
            dup          <= 1'b0;
            game_end     <= 1'b0;
        end else begin
            rec_ready_q <= rec_ready;
            hit         <= 1'b0;
            miss        <= 1'b0;
            dup         <= 1'b0;
            game_end    <= 1'b0;

            if (state != S_IDLE && (!rec_ready || restart)) begin
                // Host drop and player restart share the clear; only a
                // restart (host still ready) reports game_end back.
                state        <= S_IDLE;
                secret       <= '0;
                mask         <= '0;
                used_letters <= '0;
                mistakes     <= '0;
                game_end     <= rec_ready;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (rec_ready && !rec_ready_q) begin
                            secret       <= secret_word;
                            mask         <= load_mask;
                            used_letters <= '0;
                            mistakes     <= '0;
                            state        <= S_PLAY;
                        end
                    end
                    S_PLAY: begin
                        if (mask == 5'b11111) begin
                            state <= S_WIN;
                        end else if (guess_valid && guess_ok) begin
                            guess_q <= guess_idx;
                            state   <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        if (used_letters[guess_q]) begin
                            dup   <= 1'b1;
                            state <= S_PLAY;
                        end else begin
                            used_letters[guess_q] <= 1'b1;
                            if (|match) begin
                                mask  <= mask | match;
                                hit   <= 1'b1;
                                state <= ((mask | match) == 5'b11111) ? S_WIN : S_PLAY;
                            end else begin
                                miss <= 1'b1;
                                if (mistakes < MAX_M) begin
                                    mistakes <= mistakes + 4'd1;
                                end
                                if (mistakes >= MAX_M - 4'd1) begin
                                    mask  <= '1;
                                    state <= S_LOSE;
                                end else begin
                                    state <= S_PLAY;
                                end
                            end
                        end
                    end
                    S_LOSE: begin
                        mask <= '1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_guess_checker.sv
// Self-checking bench for guess_checker: hand-written vector tables for the
// scripted games, directed corner sequences, then randomized games scored by
// a word-level reference model.
module tb_guess_checker;

    localparam int MAXM = 6;
    localparam logic [39:0] APPLE  = 40'h4150504C45;
    localparam logic [39:0] HIDDEN = 40'h5F5F5F5F5F;

    logic        clk = 1'b0;
    logic        nRst;
    logic        rec_ready;
    logic [39:0] secret_word;
    logic        guess_valid;
    logic [7:0]  guess_letter;
    logic        restart;
    logic [39:0] display_word;
    logic [25:0] used_letters;
    logic [3:0]  mistakes;
    logic        hit, miss, dup, busy, win, lose, game_end;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    guess_checker #(.MAX_MISTAKES(MAXM)) dut (
        .clk          (clk),
        .nRst         (nRst),
        .rec_ready    (rec_ready),
        .secret_word  (secret_word),
        .guess_valid  (guess_valid),
        .guess_letter (guess_letter),
        .restart      (restart),
        .display_word (display_word),
        .used_letters (used_letters),
        .mistakes     (mistakes),
        .hit          (hit),
        .miss         (miss),
        .dup          (dup),
        .busy         (busy),
        .win          (win),
        .lose         (lose),
        .game_end     (game_end)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- reference model (word level) ----------------
    localparam int PH_IDLE = 0, PH_PLAY = 1, PH_WIN = 2, PH_LOSE = 3;
    logic [7:0]  m_sec [5];
    logic [25:0] m_used;
    int          m_mist;
    int          m_phase = PH_IDLE;

    function automatic bit is_up(input logic [7:0] b);
        return b >= 8'h41 && b <= 8'h5A;
    endfunction

    function automatic bit is_letter(input logic [7:0] b);
        return is_up(b) || (b >= 8'h61 && b <= 8'h7A);
    endfunction

    function automatic bit m_revealed(input int i);
        if (m_phase == PH_LOSE) return 1'b1;
        if (!is_up(m_sec[i])) return 1'b1;
        return m_used[int'(m_sec[i]) - 65];
    endfunction

    function automatic bit m_all_revealed();
        for (int i = 0; i < 5; i++) if (!m_revealed(i)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [39:0] m_display();
        logic [39:0] d = '0;
        if (m_phase == PH_IDLE) return HIDDEN;
        for (int i = 0; i < 5; i++) d = {d[31:0], m_revealed(i) ? m_sec[i] : 8'h5F};
        return d;
    endfunction

    function automatic void m_load(input logic [39:0] w);
        for (int i = 0; i < 5; i++) m_sec[i] = w[39-8*i -: 8];
        m_used  = '0;
        m_mist  = 0;
        m_phase = PH_PLAY;
        if (m_all_revealed()) m_phase = PH_WIN;
    endfunction

    // Returns 0 none, 1 hit, 2 miss, 3 dup.
    function automatic int m_guess(input logic [7:0] ch);
        int idx;
        bit found = 1'b0;
        if (m_phase != PH_PLAY || !is_letter(ch)) return 0;
        idx = is_up(ch) ? int'(ch) - 65 : int'(ch) - 97;
        if (m_used[idx]) return 3;
        m_used[idx] = 1'b1;
        for (int i = 0; i < 5; i++) if (int'(m_sec[i]) == 65 + idx) found = 1'b1;
        if (found) begin
            if (m_all_revealed()) m_phase = PH_WIN;
            return 1;
        end
        m_mist++;
        if (m_mist == MAXM) m_phase = PH_LOSE;
        return 2;
    endfunction

    task automatic check_state(input string name);
        chk({name, ".display"}, display_word, m_display());
        chk({name, ".used"}, used_letters, m_used);
        chk({name, ".mistakes"}, mistakes, m_mist);
        chk({name, ".win_lose_busy"}, {win, lose, busy},
            {m_phase == PH_WIN, m_phase == PH_LOSE, 1'b0});
    endtask

    // ---------------- stimulus helpers (start and end at negedge) ----------------
    task automatic guess_cycle(input logic [7:0] ch, input int kind, input bit exp_busy, input string name);
        guess_valid  = 1'b1;
        guess_letter = ch;
        @(posedge clk); @(negedge clk);
        guess_valid = 1'b0;
        chk({name, ".busy"}, busy, exp_busy);
        @(posedge clk); @(negedge clk);
        chk({name, ".pulses"}, {hit, miss, dup}, {kind == 1, kind == 2, kind == 3});
        @(posedge clk); @(negedge clk);
        chk({name, ".pulse_len"}, {hit, miss, dup}, 3'b000);
    endtask

    task automatic load_word(input logic [39:0] w);
        rec_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("load.drop_no_game_end", game_end, 0);
        secret_word = w;
        rec_ready   = 1'b1;
        @(posedge clk); @(negedge clk);
        m_load(w);
        @(posedge clk); @(negedge clk);
    endtask

    task automatic do_restart(input bit with_guess, input string name);
        bit exp_ge = (m_phase != PH_IDLE);
        restart      = 1'b1;
        guess_valid  = with_guess;
        guess_letter = "A";
        @(posedge clk); @(negedge clk);
        restart     = 1'b0;
        guess_valid = 1'b0;
        m_phase = PH_IDLE;
        m_used  = '0;
        m_mist  = 0;
        chk({name, ".game_end"}, game_end, exp_ge);
        check_state(name);
        @(posedge clk); @(negedge clk);
        chk({name, ".game_end_len"}, game_end, 0);
    endtask

    task automatic check_reset(input string name);
        chk({name, ".display"}, display_word, HIDDEN);
        chk({name, ".used"}, used_letters, 0);
        chk({name, ".mistakes"}, mistakes, 0);
        chk({name, ".flags"}, {hit, miss, dup, busy, win, lose, game_end}, 7'b0);
    endtask

    function automatic logic [39:0] rand_word();
        logic [39:0] w = '0;
        for (int i = 0; i < 5; i++)
            w = {w[31:0], ($urandom_range(0, 4) == 0) ? 8'h5F : 8'(32'h41 + $urandom_range(0, 7))};
        return w;
    endfunction

    function automatic logic [7:0] rand_letter();
        logic [7:0] c;
        if ($urandom_range(0, 9) == 0) begin
            c = 8'($urandom_range(0, 255));
        end else begin
            c = 8'(32'h41 + $urandom_range(0, 11));
            if ($urandom_range(0, 1) == 1) c = c + 8'h20;
        end
        return c;
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0]  ch;
        int          kind;
        logic [39:0] disp;
        logic [25:0] used;
        logic [3:0]  mist;
        logic        w;
        logic        l;
    } vec_t;

    vec_t tv [13];

    task automatic apply_vec(input int i);
        guess_cycle(tv[i].ch, tv[i].kind, tv[i].kind != 0, $sformatf("vec%0d", i));
        chk($sformatf("vec%0d.display", i), display_word, tv[i].disp);
        chk($sformatf("vec%0d.used", i), used_letters, tv[i].used);
        chk($sformatf("vec%0d.mistakes", i), mistakes, tv[i].mist);
        chk($sformatf("vec%0d.win_lose", i), {win, lose}, {tv[i].w, tv[i].l});
    endtask

    initial begin
        nRst = 1'b0; rec_ready = 1'b0; guess_valid = 1'b0; restart = 1'b0;
        secret_word = '0; guess_letter = '0;

        // Game A on APPLE: hits, dup, invalid, miss, then WIN.
        tv[0]  = '{8'h50, 1, 40'h5F50505F5F, 26'h0008000, 4'd0, 1'b0, 1'b0};
        tv[1]  = '{8'h50, 3, 40'h5F50505F5F, 26'h0008000, 4'd0, 1'b0, 1'b0};
        tv[2]  = '{8'h33, 0, 40'h5F50505F5F, 26'h0008000, 4'd0, 1'b0, 1'b0};
        tv[3]  = '{8'h61, 1, 40'h4150505F5F, 26'h0008001, 4'd0, 1'b0, 1'b0};
        tv[4]  = '{8'h5A, 2, 40'h4150505F5F, 26'h2008001, 4'd1, 1'b0, 1'b0};
        tv[5]  = '{8'h6C, 1, 40'h4150504C5F, 26'h2008801, 4'd1, 1'b0, 1'b0};
        tv[6]  = '{8'h65, 1, 40'h4150504C45, 26'h2008811, 4'd1, 1'b1, 1'b0};
        // Game B on APPLE: six misses, then LOSE shows the word.
        tv[7]  = '{8'h5A, 2, 40'h5F5F5F5F5F, 26'h2000000, 4'd1, 1'b0, 1'b0};
        tv[8]  = '{8'h51, 2, 40'h5F5F5F5F5F, 26'h2010000, 4'd2, 1'b0, 1'b0};
        tv[9]  = '{8'h58, 2, 40'h5F5F5F5F5F, 26'h2810000, 4'd3, 1'b0, 1'b0};
        tv[10] = '{8'h4D, 2, 40'h5F5F5F5F5F, 26'h2811000, 4'd4, 1'b0, 1'b0};
        tv[11] = '{8'h4E, 2, 40'h5F5F5F5F5F, 26'h2813000, 4'd5, 1'b0, 1'b0};
        tv[12] = '{8'h42, 2, 40'h4150504C45, 26'h2813002, 4'd6, 1'b0, 1'b1};

        #12;
        check_reset("reset");
        @(negedge clk); nRst = 1'b1;
        @(negedge clk);

        // restart in IDLE is ignored
        restart = 1'b1;
        @(posedge clk); @(negedge clk);
        restart = 1'b0;
        chk("idle_restart.game_end", game_end, 0);

        load_word(APPLE);
        chk("apple.load_display", display_word, HIDDEN);
        for (int i = 0; i <= 6; i++) apply_vec(i);

        // restart from WIN
        restart = 1'b1;
        @(posedge clk); @(negedge clk);
        restart = 1'b0;
        chk("win_restart.game_end", game_end, 1);
        chk("win_restart.display", display_word, HIDDEN);
        chk("win_restart.win_used", {win, used_letters}, 27'd0);
        @(posedge clk); @(negedge clk);
        chk("win_restart.game_end_len", game_end, 0);

        // rec_ready still high: no reload, guesses ignored
        guess_cycle("P", 0, 1'b0, "held_ready");
        chk("held_ready.used", used_letters, 0);
        chk("held_ready.display", display_word, HIDDEN);

        load_word(APPLE);
        for (int i = 7; i <= 12; i++) apply_vec(i);
        guess_cycle("A", 0, 1'b0, "lose_guess");
        chk("lose_guess.state", {lose, mistakes}, {1'b1, 4'd6});

        // strobe during CHECK is ignored
        load_word(APPLE);
        guess_valid = 1'b1; guess_letter = "Z";
        @(posedge clk); @(negedge clk);
        chk("busy.busy", busy, 1);
        guess_letter = "P";
        @(posedge clk); @(negedge clk);
        guess_valid = 1'b0;
        chk("busy.pulses", {hit, miss, dup}, 3'b010);
        @(posedge clk); @(negedge clk);
        chk("busy.ignored", {busy, hit, used_letters}, {2'b00, 26'h2000000});
        chk("busy.mistakes", mistakes, 1);

        // single-letter word
        load_word(40'h415F5F5F5F);
        guess_cycle("A", 1, 1'b1, "a_word");
        chk("a_word.win", win, 1);
        chk("a_word.display", display_word, 40'h415F5F5F5F);

        // no letters: WIN one cycle after loading
        rec_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        secret_word = HIDDEN; rec_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("blank.play", win, 0);
        @(posedge clk); @(negedge clk);
        chk("blank.win", win, 1);

        // host drop mid-game, then rising edge reloads
        load_word(APPLE);
        guess_cycle("Q", 2, 1'b1, "pre_drop");
        rec_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        check_reset("drop");
        rec_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        guess_cycle("P", 1, 1'b1, "reload_hit");

        // async reset while a guess is in CHECK
        guess_valid = 1'b1; guess_letter = "A";
        @(posedge clk);
        #2 nRst = 1'b0; guess_valid = 1'b0;
        #1 check_reset("nrst_check");
        @(negedge clk); nRst = 1'b1;

        // restart and guess in the same cycle
        load_word(APPLE);
        do_restart(1'b1, "restart_guess");

        // randomized games against the model
        for (int g = 0; g < 25; g++) begin
            load_word(rand_word());
            check_state("rand.load");
            for (int k = 0; k < 14; k++) begin
                if ($urandom_range(0, 19) == 0) begin
                    do_restart(1'($urandom_range(0, 1)), "rand.restart");
                end else begin
                    logic [7:0] ch;
                    bit eb;
                    int kind;
                    ch   = rand_letter();
                    eb   = (m_phase == PH_PLAY) && is_letter(ch);
                    kind = m_guess(ch);
                    guess_cycle(ch, kind, eb, "rand.guess");
                    check_state("rand.state");
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
